// File: rtl/spi_platform_designer_esc_pio_input.sv
// Debounced Avalon-MM PIO input port with edge capture and
// level interrupt. Pins are synchronised, debounced, then edge-detected.
module spi_platform_designer_esc_pio_input #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 1,
    parameter int EDGE_TYPE   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [15:0] DEB_L = 16'(DEBOUNCE);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][15:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]                  deb_q, deb_d;
    logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic [WIDTH-1:0]                  synced;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  clr_mask;
    logic                              wr_en;
    logic                              unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_wdata = ^writedata;

    assign synced = sync_q[SYNC_STAGES-1];
    assign wr_en  = chipselect & ~write_n;

    // Shift each pin through its synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Accept a new level only after DEBOUNCE consecutive differing cycles.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (synced[i] != deb_q[i]) begin
                if (cnt_q[i] + 16'd1 == DEB_L) begin
                    deb_d[i] = synced[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Edge qualification on the debounced level as it changes.
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = deb_d & ~deb_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~deb_d & deb_q;
        end else begin
            edge_det = deb_d ^ deb_q;
        end
    end

    // Register writes; a new edge wins over a same-cycle clear.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_mask  = '0;
        if (wr_en && address == 2'd1) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clr_mask = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    // All state, with synchronous active-low reset overriding writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_spi_platform_designer_esc_pio_input.sv
// Bench for the debounced PIO input: two instances (any-edge and
// rising-only) share stimulus; reads are scoreboarded.
module tb_spi_platform_designer_esc_pio_input;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic [31:0] readdata0;
    logic        irq;
    logic        irq0;

    int checks;
    int failures;

    logic [31:0] sb_q[$];
    logic [31:0] sb0_q[$];

    spi_platform_designer_esc_pio_input #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    spi_platform_designer_esc_pio_input #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata0), .irq(irq0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Push expectations, clock once, then pop and compare both instances.
    task automatic rd_step(input string tag, input logic [31:0] e,
                           input logic [31:0] e0);
        sb_q.push_back(e);
        sb0_q.push_back(e0);
        tick();
        chk(tag, readdata, sb_q.pop_front());
        chk({tag, "_rise"}, readdata0, sb0_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [31:0] e, input logic [31:0] e0);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        rd_step(tag, e, e0);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        ticks(2);
        reset_n = 1'b1;

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_irq_rise", {31'd0, irq0}, 32'd0);
        rd("rst_data", 2'd0, 32'h0, 32'h0);
        rd("rst_mask", 2'd1, 32'h0, 32'h0);
        rd("rst_resv", 2'd2, 32'h0, 32'h0);
        rd("rst_ecap", 2'd3, 32'h0, 32'h0);

        // irqmask load, upper writedata ignored
        wr(2'd1, 32'hABCDEF01);
        rd("mask_load", 2'd1, 32'h1, 32'h1);

        // 3-cycle glitch on bit0 is filtered
        in_port = 8'h01;
        ticks(3);
        in_port = 8'h00;
        ticks(8);
        rd("glitch_data", 2'd0, 32'h0, 32'h0);
        rd("glitch_ecap", 2'd3, 32'h0, 32'h0);
        chk("glitch_irq", {31'd0, irq}, 32'd0);

        // Exact latency: first sampling edge is k
        address = 2'd0;
        in_port = 8'h01;
        ticks(5);
        chk("lat_irq_k4", {31'd0, irq}, 32'd0);
        sb_q.push_back(32'h0);
        tick();
        chk("lat_irq_k5", {31'd0, irq}, 32'd1);
        chk("lat_irq_k5_rise", {31'd0, irq0}, 32'd1);
        chk("lat_data_k5", readdata, sb_q.pop_front());
        rd_step("lat_data_k6", 32'h1, 32'h1);

        // Write-1-to-clear drops irq on that edge
        wr(2'd3, 32'h00000001);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        chk("clr_irq_rise", {31'd0, irq0}, 32'd0);
        rd("clr_ecap", 2'd3, 32'h0, 32'h0);

        // Falling edge coincides with clear: set wins (any-edge only)
        in_port = 8'h00;
        ticks(5);
        wr(2'd3, 32'h00000001);
        chk("setwin_irq", {31'd0, irq}, 32'd1);
        chk("setwin_irq_rise", {31'd0, irq0}, 32'd0);
        rd("setwin_ecap", 2'd3, 32'h1, 32'h0);

        // Bit2 edge polarity
        wr(2'd3, 32'h000000FF);
        in_port = 8'h04;
        ticks(8);
        rd("b2_rise_ecap", 2'd3, 32'h4, 32'h4);
        wr(2'd3, 32'h000000FF);
        in_port = 8'h00;
        ticks(8);
        rd("b2_fall_ecap", 2'd3, 32'h4, 32'h0);
        in_port = 8'h04;
        ticks(8);
        rd("b2_rise2_ecap", 2'd3, 32'h4, 32'h4);
        rd("b2_data", 2'd0, 32'h4, 32'h4);

        // Reset mid-debounce, overriding a simultaneous write
        wr(2'd1, 32'h000000FF);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        in_port = 8'h80;
        ticks(3);
        reset_n    = 1'b0;
        address    = 2'd1;
        writedata  = 32'h000000FF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        reset_n    = 1'b1;
        write_n    = 1'b1;
        chipselect = 1'b0;
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_irq_rise", {31'd0, irq0}, 32'd0);
        rd("mid_rst_data", 2'd0, 32'h0, 32'h0);
        rd("mid_rst_mask", 2'd1, 32'h0, 32'h0);
        rd("mid_rst_resv", 2'd2, 32'h0, 32'h0);
        rd("mid_rst_ecap", 2'd3, 32'h0, 32'h0);
        ticks(4);
        rd("post_rst_ecap", 2'd3, 32'h80, 32'h80);
        rd("post_rst_data", 2'd0, 32'h80, 32'h80);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);

        // Reserved address ignores writes
        wr(2'd2, 32'hFFFFFFFF);
        rd("resv_wr", 2'd2, 32'h0, 32'h0);
        rd("resv_mask", 2'd1, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
